// File: rtl/morse_pkg.sv
// morse_pkg: shared constants and FSM state type for the Morse symbol decoder.
//   MAX_ELEMS        - longest symbol the buffer holds (elements)
//   ASCII_SPACE/LF   - separators emitted on word / line gaps
//   UNKNOWN_CHAR_DEF - default code for unrecognised or over-long symbols
package morse_pkg;

  localparam logic [2:0] MAX_ELEMS        = 3'd6;
  localparam logic [7:0] ASCII_SPACE      = 8'h20;
  localparam logic [7:0] ASCII_LF         = 8'h0A;
  localparam logic [7:0] UNKNOWN_CHAR_DEF = 8'h3F;

  typedef enum logic [1:0] {
    S_COLLECT   = 2'd0,
    S_PUSH_CHAR = 2'd1,
    S_PUSH_SEP  = 2'd2
  } state_t;

endpackage

// File: rtl/morse_char_lut.sv
// morse_char_lut: combinational ITU Morse lookup.
//   len      - number of elements in the symbol (0..6)
//   code     - elements, first one in bit len-1; dot=0, dash=1
//   too_long - symbol overflowed the buffer
//   ascii    - A-Z / 0-9 code, or UNKNOWN_CHAR
module morse_char_lut
  import morse_pkg::*;
#(
  parameter logic [7:0] UNKNOWN_CHAR = UNKNOWN_CHAR_DEF
) (
  input  logic [2:0] len,
  input  logic [5:0] code,
  input  logic       too_long,
  output logic [7:0] ascii
);

  // code bits above len are always zero (buffer shifts in from a cleared
  // register), so matching the full {len,code} word is exact.
  always_comb begin
    ascii = UNKNOWN_CHAR;
    if (!too_long) begin
      case ({len, code})
        {3'd1, 6'b000000}: ascii = 8'h45; // E
        {3'd1, 6'b000001}: ascii = 8'h54; // T
        {3'd2, 6'b000000}: ascii = 8'h49; // I
        {3'd2, 6'b000001}: ascii = 8'h41; // A
        {3'd2, 6'b000010}: ascii = 8'h4E; // N
        {3'd2, 6'b000011}: ascii = 8'h4D; // M
        {3'd3, 6'b000000}: ascii = 8'h53; // S
        {3'd3, 6'b000001}: ascii = 8'h55; // U
        {3'd3, 6'b000010}: ascii = 8'h52; // R
        {3'd3, 6'b000011}: ascii = 8'h57; // W
        {3'd3, 6'b000100}: ascii = 8'h44; // D
        {3'd3, 6'b000101}: ascii = 8'h4B; // K
        {3'd3, 6'b000110}: ascii = 8'h47; // G
        {3'd3, 6'b000111}: ascii = 8'h4F; // O
        {3'd4, 6'b000000}: ascii = 8'h48; // H
        {3'd4, 6'b000001}: ascii = 8'h56; // V
        {3'd4, 6'b000010}: ascii = 8'h46; // F
        {3'd4, 6'b000100}: ascii = 8'h4C; // L
        {3'd4, 6'b000110}: ascii = 8'h50; // P
        {3'd4, 6'b000111}: ascii = 8'h4A; // J
        {3'd4, 6'b001000}: ascii = 8'h42; // B
        {3'd4, 6'b001001}: ascii = 8'h58; // X
        {3'd4, 6'b001010}: ascii = 8'h43; // C
        {3'd4, 6'b001011}: ascii = 8'h59; // Y
        {3'd4, 6'b001100}: ascii = 8'h5A; // Z
        {3'd4, 6'b001101}: ascii = 8'h51; // Q
        {3'd5, 6'b011111}: ascii = 8'h30; // 0
        {3'd5, 6'b001111}: ascii = 8'h31; // 1
        {3'd5, 6'b000111}: ascii = 8'h32; // 2
        {3'd5, 6'b000011}: ascii = 8'h33; // 3
        {3'd5, 6'b000001}: ascii = 8'h34; // 4
        {3'd5, 6'b000000}: ascii = 8'h35; // 5
        {3'd5, 6'b010000}: ascii = 8'h36; // 6
        {3'd5, 6'b011000}: ascii = 8'h37; // 7
        {3'd5, 6'b011100}: ascii = 8'h38; // 8
        {3'd5, 6'b011110}: ascii = 8'h39; // 9
        default:           ascii = UNKNOWN_CHAR;
      endcase
    end
  end

endmodule

// File: rtl/morse_symbol_decoder.sv
// morse_symbol_decoder: turns dot/dash/gap pulses into an ASCII stream.
//   new_dot/new_dash             - element pulses
//   gap_letter/gap_word/gap_line - gap pulses (letter end, +space, +LF)
//   long_press_clear             - wipes buffer and FIFO, pulses clear_pulse
//   out_data/out_valid/out_ready - ready/valid character output (FIFO head)
//   overrun                      - sticky, a character was dropped on full FIFO
//   fifo_count                   - FIFO occupancy
module morse_symbol_decoder
  import morse_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] UNKNOWN_CHAR = UNKNOWN_CHAR_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          new_dot,
  input  logic                          new_dash,
  input  logic                          gap_letter,
  input  logic                          gap_word,
  input  logic                          gap_line,
  input  logic                          long_press_clear,
  output logic [7:0]                    out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          clear_pulse,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  state_t          state_q, state_d;
  logic [5:0]      code_q, code_d;
  logic [2:0]      len_q, len_d;
  logic            too_long_q, too_long_d;
  logic [7:0]      char_q, char_d;
  logic [7:0]      sep_q, sep_d;
  logic            sep_pend_q, sep_pend_d;
  logic            clear_pulse_q, clear_pulse_d;
  logic            overrun_q, overrun_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push, push_ok, pop, full;
  logic [7:0]      push_data;
  logic [7:0]      lut_char;

  morse_char_lut #(.UNKNOWN_CHAR(UNKNOWN_CHAR)) u_lut (
    .len      (len_q),
    .code     (code_q),
    .too_long (too_long_q),
    .ascii    (lut_char)
  );

  always_comb begin
    state_d       = state_q;
    code_d        = code_q;
    len_d         = len_q;
    too_long_d    = too_long_q;
    char_d        = char_q;
    sep_d         = sep_q;
    sep_pend_d    = sep_pend_q;
    clear_pulse_d = 1'b0;
    push          = 1'b0;
    push_data     = char_q;

    if (!long_press_clear) begin
      case (state_q)
        S_COLLECT: begin
          // one if-chain gives the pulse priority; losers are dropped
          if (gap_line || gap_word) begin
            sep_d      = gap_line ? ASCII_LF : ASCII_SPACE;
            sep_pend_d = 1'b1;
            char_d     = lut_char;
            state_d    = (len_q != 3'd0) ? S_PUSH_CHAR : S_PUSH_SEP;
          end else if (gap_letter) begin
            if (len_q != 3'd0) begin
              char_d  = lut_char;
              state_d = S_PUSH_CHAR;
            end
          end else if (new_dash || new_dot) begin
            if (len_q == MAX_ELEMS) begin
              too_long_d = 1'b1;
            end else begin
              code_d = {code_q[4:0], new_dash};
              len_d  = len_q + 3'd1;
            end
          end
        end
        S_PUSH_CHAR: begin
          push       = 1'b1;
          push_data  = char_q;
          code_d     = '0;
          len_d      = '0;
          too_long_d = 1'b0;
          state_d    = sep_pend_q ? S_PUSH_SEP : S_COLLECT;
        end
        S_PUSH_SEP: begin
          push       = 1'b1;
          push_data  = sep_q;
          sep_pend_d = 1'b0;
          state_d    = S_COLLECT;
        end
        default: state_d = S_COLLECT;
      endcase
    end else begin
      state_d       = S_COLLECT;
      code_d        = '0;
      len_d         = '0;
      too_long_d    = 1'b0;
      sep_pend_d    = 1'b0;
      clear_pulse_d = 1'b1;
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees a slot
  always_comb begin
    full      = (count_q == CW'(FIFO_DEPTH));
    pop       = (count_q != '0) && out_ready && !long_press_clear;
    push_ok   = push && (!full || pop);
    overrun_d = overrun_q | (push && !push_ok);
    wr_ptr_d  = wr_ptr_q + AW'(push_ok);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push_ok) - CW'(pop);
    if (long_press_clear) begin
      overrun_d = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_COLLECT;
      code_q        <= '0;
      len_q         <= '0;
      too_long_q    <= 1'b0;
      char_q        <= '0;
      sep_q         <= '0;
      sep_pend_q    <= 1'b0;
      clear_pulse_q <= 1'b0;
      overrun_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      len_q         <= len_d;
      too_long_q    <= too_long_d;
      char_q        <= char_d;
      sep_q         <= sep_d;
      sep_pend_q    <= sep_pend_d;
      clear_pulse_q <= clear_pulse_d;
      overrun_q     <= overrun_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // storage needs no reset: out_data is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_valid   = (count_q != '0);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign clear_pulse = clear_pulse_q;
  assign overrun     = overrun_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb_morse_symbol_decoder: directed scenarios plus a randomized run checked
// against a string-based Morse model and a monitor queue of transfers.
module tb_morse_symbol_decoder;

  localparam logic [5:0] P_DOT  = 6'b000001;
  localparam logic [5:0] P_DASH = 6'b000010;
  localparam logic [5:0] P_LET  = 6'b000100;
  localparam logic [5:0] P_WORD = 6'b001000;
  localparam logic [5:0] P_LINE = 6'b010000;
  localparam logic [5:0] P_CLR  = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_dot = 0, new_dash = 0, gap_letter = 0, gap_word = 0;
  logic       gap_line = 0, long_press_clear = 0, out_ready = 0;
  logic [7:0] out_data;
  logic       out_valid, clear_pulse, overrun;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] got[$];
  logic [7:0] tbl[string];

  morse_symbol_decoder #(.FIFO_DEPTH(4), .UNKNOWN_CHAR(8'h3F)) dut (
    .clk(clk), .rst(rst), .new_dot(new_dot), .new_dash(new_dash),
    .gap_letter(gap_letter), .gap_word(gap_word), .gap_line(gap_line),
    .long_press_clear(long_press_clear), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .clear_pulse(clear_pulse),
    .overrun(overrun), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // every accepted character, sampled mid-cycle before the transfer edge
  always @(negedge clk)
    if (!rst && out_valid && out_ready) got.push_back(out_data);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic init_tbl();
    string codes[36] = '{".-","-...","-.-.","-..",".","..-.","--.","....","..",
      ".---","-.-",".-..","--","-.","---",".--.","--.-",".-.","...","-","..-",
      "...-",".--","-..-","-.--","--..","-----",".----","..---","...--",
      "....-",".....","-....","--...","---..","----."};
    for (int i = 0; i < 36; i++)
      tbl[codes[i]] = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);
  endtask

  function automatic logic [7:0] ref_char(input string s);
    if (s.len() > 6 || !tbl.exists(s)) return 8'h3F;
    return tbl[s];
  endfunction

  // invariant: tasks start and end 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive(input logic [5:0] p);
    {long_press_clear, gap_line, gap_word, gap_letter, new_dash, new_dot} = p;
    @(posedge clk); #1;
    {long_press_clear, gap_line, gap_word, gap_letter, new_dash, new_dot} = '0;
  endtask

  task automatic test_reset();
    tick(2);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    total++; if (overrun !== 1'b0 || clear_pulse !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", overrun, clear_pulse); end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_letter_a();
    out_ready = 1'b1; got.delete();
    drive(P_DOT); drive(P_DASH); drive(P_LET);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL a_lat_n1 got valid=%b want=0", out_valid); end
    tick(1);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin bad++; $display("FAIL a_lat_n2 got valid=%b data=%h want 1/41", out_valid, out_data); end
    tick(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL a_drained got valid=%b want=0", out_valid); end
    tick(2);
    total++; if (got.size() != 1 || got[0] !== 8'h41) begin bad++; $display("FAIL a_transfers got n=%0d want 1 x 41", got.size()); end
  endtask

  task automatic test_digit_unknown();
    logic [7:0] exp[$] = '{8'h30, 8'h3F};
    out_ready = 1'b1; got.delete();
    repeat (5) drive(P_DASH);
    drive(P_LET); tick(3);
    repeat (7) drive(P_DOT);
    drive(P_LET); tick(3);
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL digit_count got=%0d want=%0d", got.size(), exp.size()); end
    else foreach (exp[i]) if (got[i] !== exp[i]) begin bad++; $display("FAIL digit_char[%0d] got=%h want=%h", i, got[i], exp[i]); end
  endtask

  task automatic test_word_line();
    logic [7:0] exp[$] = '{8'h45, 8'h20, 8'h0A};
    out_ready = 1'b1; got.delete();
    drive(P_DOT); drive(P_WORD); tick(4);
    drive(P_LINE); tick(4);
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL sep_count got=%0d want=%0d", got.size(), exp.size()); end
    else foreach (exp[i]) if (got[i] !== exp[i]) begin bad++; $display("FAIL sep_char[%0d] got=%h want=%h", i, got[i], exp[i]); end
  endtask

  task automatic test_priority_drop();
    logic [7:0] exp[$] = '{8'h54, 8'h45, 8'h0A, 8'h45};
    out_ready = 1'b1; got.delete();
    drive(P_DASH | P_DOT); drive(P_LET); tick(3);
    drive(P_DOT); drive(P_LINE | P_WORD | P_LET | P_DASH); tick(4);
    // a dot landing in the push cycle is lost, so the next gap has nothing
    drive(P_DOT); drive(P_LET); drive(P_DOT); drive(P_LET); tick(3);
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL prio_count got=%0d want=%0d", got.size(), exp.size()); end
    else foreach (exp[i]) if (got[i] !== exp[i]) begin bad++; $display("FAIL prio_char[%0d] got=%h want=%h", i, got[i], exp[i]); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0; got.delete();
    repeat (5) begin drive(P_DOT); drive(P_LET); tick(2); end
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d want=4", fifo_count); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", overrun); end
    total++; if (out_data !== 8'h45) begin bad++; $display("FAIL ovr_hold got=%h want=45", out_data); end
    out_ready = 1'b1; tick(6);
    total++; if (got.size() != 4 || out_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got n=%0d valid=%b want 4/0", got.size(), out_valid); end
    foreach (got[i]) begin
      total++; if (got[i] !== 8'h45) begin bad++; $display("FAIL ovr_char[%0d] got=%h want=45", i, got[i]); end
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0; got.delete();
    drive(P_DOT); drive(P_LET); tick(2);
    drive(P_DOT); drive(P_LET); tick(2);
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL clr_pre got=%0d want=2", fifo_count); end
    drive(P_DASH); drive(P_CLR);
    total++; if (fifo_count !== 3'd0 || clear_pulse !== 1'b1) begin bad++; $display("FAIL clr_now got count=%0d pulse=%b want 0/1", fifo_count, clear_pulse); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL clr_overrun got=%b want=0", overrun); end
    tick(1);
    total++; if (clear_pulse !== 1'b0) begin bad++; $display("FAIL clr_pulse_len got=%b want=0", clear_pulse); end
    drive(P_LET); tick(3);
    out_ready = 1'b1; tick(2);
    total++; if (fifo_count !== 3'd0 || got.size() != 0) begin bad++; $display("FAIL clr_after got count=%0d n=%0d want 0/0", fifo_count, got.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; got.delete();
    drive(P_DOT); drive(P_WORD); tick(1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pre got valid=%b want=1", out_valid); end
    #3 rst = 1'b1;
    #1;
    total++; if ({out_valid, clear_pulse, overrun, fifo_count, out_data} !== '0) begin
      bad++; $display("FAIL rmid_async got v=%b c=%b o=%b n=%0d d=%h want all 0", out_valid, clear_pulse, overrun, fifo_count, out_data); end
    @(posedge clk); #1; rst = 1'b0;
    tick(3); out_ready = 1'b1; tick(3);
    total++; if (got.size() != 0 || fifo_count !== 3'd0) begin bad++; $display("FAIL rmid_after got n=%0d count=%0d want 0/0", got.size(), fifo_count); end
  endtask

  task automatic test_random();
    logic [7:0] exp[$];
    string sym = "";
    int r;
    out_ready = 1'b1; got.delete();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin sym = {sym, "."}; drive(P_DOT); end
      else if (r < 8) begin sym = {sym, "-"}; drive(P_DASH); end
      else if (r == 8) begin
        if (sym.len() > 0) exp.push_back(ref_char(sym));
        sym = ""; drive(P_LET); tick(2);
      end else begin
        if (sym.len() > 0) exp.push_back(ref_char(sym));
        if ($urandom_range(0, 1) == 1) begin exp.push_back(8'h0A); drive(P_LINE); end
        else begin exp.push_back(8'h20); drive(P_WORD); end
        sym = ""; tick(3);
      end
      tick($urandom_range(0, 1));
    end
    if (sym.len() > 0) exp.push_back(ref_char(sym));
    drive(P_LET); tick(6);
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got.size(), exp.size()); end
    else foreach (exp[i]) if (got[i] !== exp[i]) begin bad++; $display("FAIL rand_char[%0d] got=%h want=%h", i, got[i], exp[i]); end
  endtask

  initial begin
    init_tbl();
    #1;
    test_reset();
    test_letter_a();
    test_digit_unknown();
    test_word_line();
    test_priority_drop();
    test_overrun();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_symbol_decoder.md
MORSE_SYMBOL_DECODER -- requirements
Module: morse_symbol_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output character FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter UNKNOWN_CHAR, default 8'h3F, ASCII code emitted for an unrecognised or over-long symbol.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports new_dot, new_dash  in  1 each  1-cycle element pulses from the timing stage.
REQ-006 SHALL have ports gap_letter, gap_word, gap_line  in  1 each  1-cycle gap pulses.
REQ-007 SHALL have port long_press_clear  in  1  1-cycle clear request.
REQ-008 SHALL have port out_data  out  8  ASCII character at FIFO head.
REQ-009 SHALL have port out_valid  out  1  FIFO non-empty.
REQ-010 SHALL have port out_ready  in  1  consumer accept; transfer when out_valid && out_ready.
REQ-011 SHALL have port clear_pulse  out  1  1-cycle pulse telling downstream display to clear.
REQ-012 SHALL have port overrun  out  1  sticky: a character was dropped on full FIFO.
REQ-013 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-014 SHALL hold a symbol buffer: code[5:0] and len[2:0] (0..6); dot shifts in 0, dash shifts in 1 (code <= {code[4:0],bit}), first element ends up MSB of the len used bits.
REQ-015 SHALL set an internal too_long flag, leave code/len unchanged, when an element arrives with len==6.
REQ-016 SHALL have FSM states S_COLLECT, S_PUSH_CHAR, S_PUSH_SEP; reset state S_COLLECT.
REQ-017 In S_COLLECT, gap_letter with len>0 SHALL latch the looked-up char and go to S_PUSH_CHAR; with len==0 it SHALL be ignored.
REQ-018 In S_COLLECT, gap_word SHALL latch separator 8'h20, gap_line separator 8'h0A; next state S_PUSH_CHAR if len>0, else S_PUSH_SEP.
REQ-019 S_PUSH_CHAR SHALL last exactly 1 cycle: push char, clear code/len/too_long, go to S_PUSH_SEP if a separator is pending else S_COLLECT.
REQ-020 S_PUSH_SEP SHALL last exactly 1 cycle: push separator, return to S_COLLECT.
REQ-021 Lookup SHALL map A-Z to 8'h41-8'h5A and 0-9 to 8'h30-8'h39 per ITU Morse; any other (len,code) or too_long SHALL yield UNKNOWN_CHAR.
REQ-022 Latency: gap pulse in cycle N SHALL make the character visible on out_data/out_valid in cycle N+2 when the FIFO was empty.
REQ-023 Simultaneous pulses in S_COLLECT priority: long_press_clear > gap_line > gap_word > gap_letter > new_dash > new_dot; lower ones dropped.
REQ-024 Element or gap pulses arriving in S_PUSH_CHAR/S_PUSH_SEP SHALL be dropped; long_press_clear SHALL still be honoured.
REQ-025 long_press_clear in any state SHALL, next edge: clear symbol buffer, empty FIFO, clear overrun, go to S_COLLECT, assert clear_pulse for 1 cycle.
REQ-026 Push to a full FIFO SHALL drop the character and set overrun; push and pop in same cycle when full SHALL both succeed.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; out_data SHALL be stable while out_valid && !out_ready.

Reset
REQ-028 rst asserted SHALL asynchronously force: S_COLLECT, code=0, len=0, too_long=0, FIFO empty, out_valid=0, out_data=0, clear_pulse=0, overrun=0, fifo_count=0.
REQ-029 Reset mid-symbol or mid-push SHALL discard all pending data; no character emitted after release.

Structure
REQ-030 Shared package morse_pkg SHALL hold MAX_ELEMS=6, ASCII_SPACE=8'h20, ASCII_LF=8'h0A, default UNKNOWN_CHAR, and the FSM state enum.
REQ-031 Lookup SHALL be a combinational sub-module morse_char_lut (in: len, code, too_long; out: 8-bit ASCII); FIFO inline.

Verification
REQ-032 dot, dash, gap_letter, out_ready=1 -> out_data=8'h41 ('A') valid 2 cycles after gap_letter, one transfer.
REQ-033 five dashes, gap_letter -> 8'h30; seven dots, gap_letter -> 8'h3F.
REQ-034 dot, gap_word -> 8'h45 then 8'h20 on consecutive pushes; gap_line with len==0 -> single 8'h0A.
REQ-035 out_ready=0, five letters "E" -> fifo_count=4, overrun=1; then out_ready=1 -> four 8'h45 drained, out_valid=0.
REQ-036 two letters queued, dash pending, long_press_clear -> next cycle fifo_count=0, clear_pulse=1 for 1 cycle, following gap_letter emits nothing.
REQ-037 rst asserted during S_PUSH_SEP -> all outputs 0 immediately, no character after release.
